// File: rtl/rtc_pkg.sv
// Shared widths, limits, alarm state encoding and 12h display helper for the RTC slice.
package rtc_pkg;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
   localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
   localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;

   typedef enum logic [1:0] {
      ALM_IDLE,
      ALM_RING,
      ALM_SNOOZE
   } alm_state_t;

   // Returns {pm, disp_hour}; midnight and noon both display as 12.
   function automatic logic [HOUR_W:0] to_12h(input logic [HOUR_W-1:0] hour);
      logic                pm_f;
      logic [HOUR_W-1:0]   h;
      pm_f = (hour >= 5'd12);
      if (hour == '0)
         h = 5'd12;
      else if (hour > 5'd12)
         h = hour - 5'd12;
      else
         h = hour;
      return {pm_f, h};
   endfunction

endpackage

// File: rtl/rtc_mod_counter.sv
// Modulo-MOD counter with clear/load/increment; carry is combinational on the wrapping increment.
module rtc_mod_counter #(
   parameter int MOD = 60,
   parameter int W   = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] ld_val,
   output logic [W-1:0] value,
   output logic         carry
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   assign carry = inc & (value == LAST);

   always_ff @(posedge clk) begin
      if (reset || clr)
         value <= '0;
      else if (load)
         value <= ld_val;
      else if (inc)
         value <= carry ? '0 : value + W'(1);
   end

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day counter with runtime set, 12/24h display, day rollover and snoozable alarm.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ALM_IDLE   | armed on the programmed target (if alm_en), not ringing
// ALM_RING   | alarm asserted on alm_irq, waiting for ack or snooze
// ALM_SNOOZE | silenced, armed on the snooze target
module rtc_timekeeper
   import rtc_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100,
   parameter int SNOOZE_MIN    = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              pause,
   input  logic              mode_12h,
   input  logic              set_valid,
   output logic              set_ready,
   input  logic [HOUR_W-1:0] set_hour,
   input  logic [MIN_W-1:0]  set_min,
   input  logic [SEC_W-1:0]  set_sec,
   output logic              set_err,
   input  logic              alm_wr,
   input  logic [HOUR_W-1:0] alm_hour,
   input  logic [MIN_W-1:0]  alm_min,
   input  logic              alm_en,
   input  logic              alm_ack,
   input  logic              alm_snooze,
   output logic [HOUR_W-1:0] hour,
   output logic [MIN_W-1:0]  minute,
   output logic [SEC_W-1:0]  second,
   output logic [HOUR_W-1:0] disp_hour,
   output logic              pm,
   output logic              sec_tick,
   output logic              day_tick,
   output logic              alm_irq
);

   localparam int SUB_W = $clog2(TICKS_PER_SEC);

   logic              set_acc, set_in_range, set_load, run;
   logic [SUB_W-1:0]  sub_val;
   logic              unused_sub;
   logic              sub_carry, sec_carry, min_carry, hour_carry;
   logic [MIN_W-1:0]  new_min;
   logic [HOUR_W-1:0] new_hour;
   logic              alm_wr_ok, hit_alm, hit_snz;
   logic [HOUR_W-1:0] tgt_hour, snz_hour, snz_hour_nxt;
   logic [MIN_W-1:0]  tgt_min, snz_min, snz_min_nxt;
   logic [MIN_W:0]    snz_sum;
   alm_state_t        state, state_nxt;

   assign set_ready    = ~clr;
   assign set_acc      = set_valid & set_ready;
   assign set_in_range = (set_hour <= MAX_HOUR) && (set_min <= MAX_MIN) && (set_sec <= MAX_SEC);
   assign set_load     = set_acc & set_in_range;
   // Counting is suppressed by clr, an accepted in-range set, or pause.
   assign run          = ~clr & ~set_load & ~pause;

   rtc_mod_counter #(.MOD(TICKS_PER_SEC), .W(SUB_W)) u_sub (
      .clk(clk), .reset(reset), .inc(run), .clr(clr), .load(set_load),
      .ld_val('0), .value(sub_val), .carry(sub_carry)
   );

   rtc_mod_counter #(.MOD(60), .W(SEC_W)) u_sec (
      .clk(clk), .reset(reset), .inc(sub_carry), .clr(clr), .load(set_load),
      .ld_val(set_sec), .value(second), .carry(sec_carry)
   );

   rtc_mod_counter #(.MOD(60), .W(MIN_W)) u_min (
      .clk(clk), .reset(reset), .inc(sec_carry), .clr(clr), .load(set_load),
      .ld_val(set_min), .value(minute), .carry(min_carry)
   );

   rtc_mod_counter #(.MOD(24), .W(HOUR_W)) u_hour (
      .clk(clk), .reset(reset), .inc(min_carry), .clr(clr), .load(set_load),
      .ld_val(set_hour), .value(hour), .carry(hour_carry)
   );

   assign unused_sub = ^sub_val;

   assign {pm, disp_hour} = mode_12h ? to_12h(hour) : {1'b0, hour};

   // hour:minute as it will read after the current second wraps.
   assign new_min  = (minute == MAX_MIN) ? '0 : minute + MIN_W'(1);
   assign new_hour = (minute != MAX_MIN) ? hour :
                     (hour == MAX_HOUR) ? '0 : hour + HOUR_W'(1);

   assign alm_wr_ok = alm_wr && (alm_hour <= MAX_HOUR) && (alm_min <= MAX_MIN);
   assign hit_alm   = sec_carry && (new_hour == tgt_hour) && (new_min == tgt_min);
   assign hit_snz   = sec_carry && (new_hour == snz_hour) && (new_min == snz_min);

   always_comb begin
      snz_sum      = {1'b0, snz_min} + (MIN_W+1)'(SNOOZE_MIN);
      snz_min_nxt  = snz_sum[MIN_W-1:0];
      snz_hour_nxt = snz_hour;
      if (snz_sum > {1'b0, MAX_MIN}) begin
         snz_min_nxt  = snz_min + MIN_W'(SNOOZE_MIN) - MIN_W'(60);
         snz_hour_nxt = (snz_hour == MAX_HOUR) ? '0 : snz_hour + HOUR_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      if (!alm_en) begin
         state_nxt = ALM_IDLE;
      end else begin
         case (state)
            ALM_IDLE:   if (hit_alm) state_nxt = ALM_RING;
            ALM_RING:   if (alm_ack) state_nxt = ALM_IDLE;
                        else if (alm_snooze) state_nxt = ALM_SNOOZE;
            ALM_SNOOZE: if (alm_wr_ok) state_nxt = ALM_IDLE;
                        else if (hit_snz) state_nxt = ALM_RING;
            default:    state_nxt = ALM_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ALM_IDLE;
         alm_irq  <= 1'b0;
         tgt_hour <= '0;
         tgt_min  <= '0;
         snz_hour <= '0;
         snz_min  <= '0;
         set_err  <= 1'b0;
         sec_tick <= 1'b0;
         day_tick <= 1'b0;
      end else begin
         state    <= state_nxt;
         alm_irq  <= (state_nxt == ALM_RING);
         set_err  <= set_acc & ~set_in_range;
         sec_tick <= sub_carry;
         day_tick <= hour_carry;
         if (alm_wr_ok) begin
            tgt_hour <= alm_hour;
            tgt_min  <= alm_min;
         end
         // Snooze target chains from whichever target last rang.
         if (state == ALM_IDLE && state_nxt == ALM_RING) begin
            snz_hour <= tgt_hour;
            snz_min  <= tgt_min;
         end else if (state == ALM_RING && state_nxt == ALM_SNOOZE) begin
            snz_hour <= snz_hour_nxt;
            snz_min  <= snz_min_nxt;
         end
      end
   end

endmodule
